crt_status_sync: RTL and testbench
==================================

Name: crt_status_sync

Overview:
- Host-clock-side status and interrupt stage for the CRT controller.
- Takes asynchronous status from the CRT pixel-clock timer and synchronizes it into hclock:
  - vertical blank level
  - Gray-coded line counter
  - display-start-latched toggle
- Produces vblnkst, lcounter_stat and ad_strst, which feed the CRT register file.
- Uses the register file's vicount/hicount to raise frame-count and line-match interrupts.

Parameters:
- SYNC_STAGES, 2, synchronizer depth (legal values 2 or 3) for all asynchronous inputs.
- LCW, 12, line counter width.

Ports:
- hclock  in  1  host clock; all logic is in this domain.
- hnreset  in  1  asynchronous, active-low reset.
- crt_vblank_a  in  1  async vertical blank level from the CRT timer.
- crt_lcount_gray_a  in  LCW  async Gray-coded line counter; at most 1 bit changes per CRT line.
- crt_dstart_tog_a  in  1  async toggle; it flips each time the CRT side latches a new display start address.
- vicount  in  8  frame interrupt interval, in frames; 0 disables the interrupt.
- hicount  in  LCW  line-match compare value.
- int_en  in  2  interrupt enables: bit0 frame, bit1 line.
- int_clr  in  2  one-cycle write-1-to-clear strobes for the sticky bits.
- vblnkst  out  1  synchronized vblank.
- lcounter_stat  out  LCW  stable binary line count.
- ad_strst  out  1  one-hclock pulse per display-start latch.
- int_stat  out  2  sticky interrupt status: bit0 frame, bit1 line.
- crt_int_n  out  1  active-low interrupt, ~|(int_stat & int_en).

Behaviour:
- Reset values:
  - vblnkst=0, lcounter_stat=0, ad_strst=0, int_stat=0, crt_int_n=1.
  - All synchronizer flops, edge-history flops and the frame counter are 0.
- Vblank path:
  - SYNC_STAGES-flop synchronizer; vblnkst = last stage.
  - Latency from a stable input change to vblnkst is SYNC_STAGES hclocks.
  - One extra history flop forms vb_rise = vblnkst & ~vb_d. vb_rise is high for exactly 1 cycle.
- Line count path:
  - Each bit goes through the SYNC_STAGES-flop synchronizer, then Gray-to-binary conversion (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]).
  - The converted value is registered as lc_prev.
  - lcounter_stat loads the converted value only when converted == lc_prev and converted != lcounter_stat, i.e. two consecutive equal samples (filter).
  - lc_upd pulses 1 cycle on each load.
  - Wrap from 0xFFF to 0 is an ordinary update.
- Display-start path:
  - Synchronizer, then one history flop; ad_strst = sync ^ hist.
  - Every input toggle yields exactly one 1-cycle pulse.
  - Toggles spaced fewer than SYNC_STAGES+1 hclocks apart are not required to be resolved; the CRT side guarantees at most one toggle per frame.
- Frame counter (8-bit fcnt):
  - Increments on vb_rise.
  - When vb_rise occurs and fcnt+1 == vicount: set int_stat[0] and reload fcnt=0.
  - vicount==0: fcnt held at 0 and no frame interrupt.
  - A vicount write that drops below the current fcnt: fcnt keeps counting, wraps at 255 and matches on the next pass. No special handling.
- Line match:
  - int_stat[1] sets on lc_upd when the new lcounter_stat == hicount.
  - hicount==0 is a legal match at line 0.
- Sticky bits:
  - int_stat[n] clears on int_clr[n].
  - If set and clear occur in the same cycle, set wins.
  - Bits set independently of int_en.
  - crt_int_n is registered: it follows int_stat/int_en with 1 cycle of latency.
- Reset mid-operation: all state clears asynchronously. No ad_strst pulse is generated on reset exit, even if crt_dstart_tog_a=1; the synchronizer and history flops refill together.

Test Plan:
- Reset release with crt_dstart_tog_a=1 and crt_vblank_a=1 → no ad_strst pulse; vblnkst rises exactly 2 hclocks after hnreset deassert (SYNC_STAGES=2); int_stat=0.
- Toggle crt_dstart_tog_a 0→1→0, 40 hclocks apart → exactly two 1-cycle ad_strst pulses, each 3 hclocks after its edge.
- Drive Gray sequence 0x000..0x00F, one code per 8 hclocks, then 0xFFF→0x000 wrap (Gray 0x800→0x000) → lcounter_stat steps 0..15 in order and wraps to 0; no intermediate value appears on a glitched single-cycle input.
- vicount=3, int_en=01, 7 vblank pulses → int_stat[0] sets on the 3rd and 6th rise; crt_int_n low 1 cycle after each set; int_clr[0] between them clears it; vicount=0 → no sets.
- hicount=0x10A, line count sweeps 0x100..0x110 → int_stat[1] sets only when lcounter_stat=0x10A; int_clr[1] in the same cycle as a set leaves the bit at 1.
- Assert hnreset mid-frame with fcnt=2, int_stat=11 → all outputs return to reset values immediately; after release, first frame interrupt needs a full vicount frames.

Source files
------------

// File: rtl/crt_status_sync_if.sv
// crt_status_sync_if: register-file side of the CRT host-clock status stage.
interface crt_status_sync_if #(parameter int LCW = 12);
  logic [7:0]     vicount;
  logic [LCW-1:0] hicount;
  logic [1:0]     int_en;
  logic [1:0]     int_clr;
  logic           vblnkst;
  logic [LCW-1:0] lcounter_stat;
  logic           ad_strst;
  logic [1:0]     int_stat;
  logic           crt_int_n;
  modport master (
    output vicount, hicount, int_en, int_clr,
    input  vblnkst, lcounter_stat, ad_strst, int_stat, crt_int_n
  );
  modport slave (
    input  vicount, hicount, int_en, int_clr,
    output vblnkst, lcounter_stat, ad_strst, int_stat, crt_int_n
  );
endinterface

// File: rtl/crt_status_sync.sv
// crt_status_sync: synchronizes CRT timer status into hclock and raises
// frame-count and line-match interrupts for the CRT register file.
module crt_status_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int LCW         = 12
) (
  input  logic                 hclock,
  input  logic                 hnreset,
  input  logic                 crt_vblank_a,
  input  logic [LCW-1:0]       crt_lcount_gray_a,
  input  logic                 crt_dstart_tog_a,
  crt_status_sync_if.slave     rf
);
  logic [SYNC_STAGES-1:0]          vb_sync_q, vb_sync_d, ds_sync_q, ds_sync_d;
  logic [SYNC_STAGES-1:0][LCW-1:0] lc_sync_q, lc_sync_d;
  logic [SYNC_STAGES:0]            fill_q, fill_d;
  logic                            vb_hist_q, vb_hist_d, ds_hist_q, ds_hist_d;
  logic                            ad_strst_q, ad_strst_d, crt_int_n_q, crt_int_n_d;
  logic [LCW-1:0]                  lc_prev_q, lc_prev_d, lc_stat_q, lc_stat_d;
  logic [LCW-1:0]                  lc_gray, lc_bin;
  logic [7:0]                      fcnt_q, fcnt_d;
  logic [1:0]                      int_stat_q, int_stat_d, int_set;
  logic                            vblnkst, vb_rise, lc_upd, ds_sync;

  always_comb begin
    vb_sync_d   = {vb_sync_q[SYNC_STAGES-2:0], crt_vblank_a};
    ds_sync_d   = {ds_sync_q[SYNC_STAGES-2:0], crt_dstart_tog_a};
    lc_sync_d   = {lc_sync_q[SYNC_STAGES-2:0], crt_lcount_gray_a};
    vblnkst     = vb_sync_q[SYNC_STAGES-1];
    vb_hist_d   = vblnkst;
    vb_rise     = vblnkst & ~vb_hist_q;
    lc_gray     = lc_sync_q[SYNC_STAGES-1];
    lc_bin      = '0;
    for (int i = 0; i < LCW; i++) lc_bin[i] = ^(lc_gray >> i);
    lc_prev_d   = lc_bin;
    // two equal consecutive samples reject a value caught mid-transition
    lc_upd      = (lc_bin == lc_prev_q) && (lc_bin != lc_stat_q);
    lc_stat_d   = lc_upd ? lc_bin : lc_stat_q;
    // ad_strst is held off until the toggle synchronizer and history have refilled
    fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
    ds_sync     = ds_sync_q[SYNC_STAGES-1];
    ds_hist_d   = ds_sync;
    ad_strst_d  = fill_q[SYNC_STAGES] & (ds_sync ^ ds_hist_q);
    int_set[0]  = vb_rise && (rf.vicount != 8'd0) && (fcnt_q + 8'd1 == rf.vicount);
    int_set[1]  = lc_upd && (lc_bin == rf.hicount);
    fcnt_d      = (rf.vicount == 8'd0 || int_set[0]) ? 8'd0 : fcnt_q + {7'd0, vb_rise};
    int_stat_d  = (int_stat_q & ~rf.int_clr) | int_set;
    crt_int_n_d = ~|(int_stat_q & rf.int_en);
  end

  always_ff @(posedge hclock or negedge hnreset)
    if (!hnreset) begin
      vb_sync_q   <= '0;
      ds_sync_q   <= '0;
      lc_sync_q   <= '0;
      fill_q      <= '0;
      vb_hist_q   <= 1'b0;
      ds_hist_q   <= 1'b0;
      ad_strst_q  <= 1'b0;
      crt_int_n_q <= 1'b1;
      lc_prev_q   <= '0;
      lc_stat_q   <= '0;
      fcnt_q      <= '0;
      int_stat_q  <= '0;
    end else begin
      vb_sync_q   <= vb_sync_d;
      ds_sync_q   <= ds_sync_d;
      lc_sync_q   <= lc_sync_d;
      fill_q      <= fill_d;
      vb_hist_q   <= vb_hist_d;
      ds_hist_q   <= ds_hist_d;
      ad_strst_q  <= ad_strst_d;
      crt_int_n_q <= crt_int_n_d;
      lc_prev_q   <= lc_prev_d;
      lc_stat_q   <= lc_stat_d;
      fcnt_q      <= fcnt_d;
      int_stat_q  <= int_stat_d;
    end

  assign rf.vblnkst       = vblnkst;
  assign rf.lcounter_stat = lc_stat_q;
  assign rf.ad_strst      = ad_strst_q;
  assign rf.int_stat      = int_stat_q;
  assign rf.crt_int_n     = crt_int_n_q;
endmodule

// File: tb/tb_crt_status_sync.sv
// tb_crt_status_sync: directed checks of sync latency, line filter, toggle pulses and interrupts.
module tb_crt_status_sync;
  logic        hclock;
  logic        hnreset;
  logic        crt_vblank_a;
  logic [11:0] crt_lcount_gray_a;
  logic        crt_dstart_tog_a;
  int          errors;
  int          checks;
  logic [1:0]  st;
  logic [7:0]  fc;

  crt_status_sync_if #(.LCW(12)) rf ();

  crt_status_sync #(.SYNC_STAGES(2), .LCW(12)) dut (
    .hclock            (hclock),
    .hnreset           (hnreset),
    .crt_vblank_a      (crt_vblank_a),
    .crt_lcount_gray_a (crt_lcount_gray_a),
    .crt_dstart_tog_a  (crt_dstart_tog_a),
    .rf                (rf)
  );

  initial hclock = 1'b0;
  always #5 hclock = ~hclock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge hclock);
    #1;
  endtask

  function automatic logic [11:0] to_gray(input logic [11:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic clr(input logic [1:0] m);
    rf.int_clr = m;
    tick(1);
    rf.int_clr = 2'b00;
    st = st & ~m;
    chk("clr_stat", rf.int_stat, st);
  endtask

  task automatic ds_toggle();
    int cnt;
    int at;
    cnt = 0;
    at  = 0;
    crt_dstart_tog_a = ~crt_dstart_tog_a;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (rf.ad_strst) begin
        cnt++;
        at = i;
      end
    end
    chk("ds_cnt", cnt, 1);
    chk("ds_lat", at, 3);
  endtask

  task automatic vb_pulse();
    logic [1:0] prev;
    prev = st;
    if (rf.vicount == 8'd0) fc = 8'd0;
    else begin
      fc = fc + 8'd1;
      if (fc == rf.vicount) begin
        fc = 8'd0;
        st[0] = 1'b1;
      end
    end
    crt_vblank_a = 1'b1;
    tick(3);
    chk("frm_stat", rf.int_stat, st);
    chk("frm_int_n_old", rf.crt_int_n, ~|(prev & rf.int_en));
    tick(1);
    chk("frm_int_n_new", rf.crt_int_n, ~|(st & rf.int_en));
    tick(6);
    crt_vblank_a = 1'b0;
    tick(10);
  endtask

  task automatic set_line(input logic [11:0] v);
    crt_lcount_gray_a = to_gray(v);
    tick(8);
    chk("lc_val", rf.lcounter_stat, v);
  endtask

  initial begin
    int cnt;
    errors = 0;
    checks = 0;
    st = 2'b00;
    fc = 8'd0;
    hnreset = 1'b0;
    crt_vblank_a = 1'b1;
    crt_dstart_tog_a = 1'b1;
    crt_lcount_gray_a = 12'd0;
    rf.vicount = 8'd0;
    rf.hicount = 12'd0;
    rf.int_en = 2'b00;
    rf.int_clr = 2'b00;
    tick(3);
    chk("rst_vblnkst", rf.vblnkst, 0);
    chk("rst_lc", rf.lcounter_stat, 0);
    chk("rst_ad", rf.ad_strst, 0);
    chk("rst_stat", rf.int_stat, 0);
    chk("rst_int_n", rf.crt_int_n, 1);
    hnreset = 1'b1;
    cnt = 0;
    tick(1);
    chk("vb_lat1", rf.vblnkst, 0);
    if (rf.ad_strst) cnt++;
    tick(1);
    chk("vb_lat2", rf.vblnkst, 1);
    for (int i = 0; i < 10; i++) begin
      if (rf.ad_strst) cnt++;
      tick(1);
    end
    chk("rst_exit_ad", cnt, 0);
    chk("rst_exit_stat", rf.int_stat, 0);

    ds_toggle();
    ds_toggle();
    ds_toggle();

    for (int v = 1; v < 16; v++) set_line(12'(v));
    set_line(12'hFFF);
    set_line(12'h000);
    st[1] = 1'b1;
    chk("lc_hic0", rf.int_stat, st);
    clr(2'b10);
    crt_lcount_gray_a = to_gray(12'd5);
    tick(1);
    crt_lcount_gray_a = 12'd0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (rf.lcounter_stat != 12'd0) cnt++;
    end
    chk("lc_glitch", cnt, 0);

    crt_vblank_a = 1'b0;
    tick(10);
    rf.vicount = 8'd3;
    rf.int_en = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      vb_pulse();
      if (k == 3) clr(2'b01);
    end
    clr(2'b01);
    rf.vicount = 8'd0;
    for (int k = 0; k < 4; k++) vb_pulse();

    rf.hicount = 12'h10A;
    rf.int_en = 2'b11;
    for (int v = 12'h100; v <= 12'h110; v++) begin
      set_line(12'(v));
      if (v == 12'h10A) st[1] = 1'b1;
      chk("lm_stat", rf.int_stat, st);
      if (v == 12'h10A) clr(2'b10);
    end
    crt_lcount_gray_a = to_gray(12'h10A);
    tick(3);
    chk("lm_pre_lc", rf.lcounter_stat, 12'h110);
    chk("lm_pre_stat", rf.int_stat, st);
    rf.int_clr = 2'b10;
    tick(1);
    rf.int_clr = 2'b00;
    st[1] = 1'b1;
    chk("lm_setwins_lc", rf.lcounter_stat, 12'h10A);
    chk("lm_setwins", rf.int_stat, st);

    rf.vicount = 8'd3;
    fc = 8'd0;
    for (int k = 0; k < 5; k++) vb_pulse();
    chk("pre_rst_stat", rf.int_stat, 2'b11);
    #3;
    hnreset = 1'b0;
    #1;
    chk("mid_rst_stat", rf.int_stat, 0);
    chk("mid_rst_int_n", rf.crt_int_n, 1);
    chk("mid_rst_lc", rf.lcounter_stat, 0);
    chk("mid_rst_ad", rf.ad_strst, 0);
    chk("mid_rst_vb", rf.vblnkst, 0);
    st = 2'b00;
    fc = 8'd0;
    crt_lcount_gray_a = 12'd0;
    tick(2);
    hnreset = 1'b1;
    tick(5);
    for (int k = 0; k < 3; k++) vb_pulse();
    chk("post_rst_frame", rf.int_stat, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
